// File: rtl/cpu_pkg.sv
// Shared constants for the result scoreboard: lane/slot indices, register file
// geometry and default lane latencies.
package cpu_pkg;

    localparam int REG_W      = 5;
    localparam int NUM_REGS   = 32;
    localparam int NUM_LANES  = 4;
    localparam int NUM_SRC    = 9;
    localparam int RDY_W      = 2;
    localparam int LANE_CNT_W = 3;

    localparam int LANE_A0 = 0;
    localparam int LANE_A1 = 1;
    localparam int LANE_M  = 2;
    localparam int LANE_LS = 3;

    localparam int SRC_A0_R0 = 0;
    localparam int SRC_A0_R1 = 1;
    localparam int SRC_A1_R0 = 2;
    localparam int SRC_A1_R1 = 3;
    localparam int SRC_M_R0  = 4;
    localparam int SRC_M_R1  = 5;
    localparam int SRC_LS_R0 = 6;
    localparam int SRC_LS_R1 = 7;
    localparam int SRC_LS_R2 = 8;

    localparam int DEF_LAT_ALU = 1;
    localparam int DEF_LAT_MUL = 3;
    localparam int DEF_LAT_LS  = 2;
    localparam int DEF_CNT_W   = 3;

    // Cycles a consumer must still wait after the issue edge.
    function automatic logic [RDY_W-1:0] rdy_load(input int lat);
        return RDY_W'(lat - 1);
    endfunction

endpackage

// File: rtl/sb_entry.sv
// One tracked register: readiness countdown and saturating outstanding-writer
// count with net increment/decrement applied in a single cycle.
module sb_entry
    import cpu_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  load_i,
    input  logic [RDY_W-1:0]      load_val_i,
    input  logic [LANE_CNT_W-1:0] inc_n_i,
    input  logic [LANE_CNT_W-1:0] dec_m_i,
    output logic [RDY_W-1:0]      rdy_cnt_o,
    output logic [CNT_W-1:0]      out_cnt_o
);

    localparam int SUM_W = CNT_W + LANE_CNT_W + 1;

    logic [RDY_W-1:0] rdy_q, rdy_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic [SUM_W-1:0] sum_s, dec_s, max_s;

    // Next-state: reload beats decrement; retires beyond the count floor at zero.
    always_comb begin
        rdy_d = rdy_q;
        out_d = out_q;
        sum_s = SUM_W'(out_q) + SUM_W'(inc_n_i);
        dec_s = SUM_W'(dec_m_i);
        max_s = SUM_W'({CNT_W{1'b1}});
        if (load_i) begin
            rdy_d = load_val_i;
        end else if (rdy_q != '0) begin
            rdy_d = rdy_q - RDY_W'(1);
        end else begin
            rdy_d = rdy_q;
        end
        if (dec_s >= sum_s) begin
            out_d = '0;
        end else if ((sum_s - dec_s) > max_s) begin
            out_d = {CNT_W{1'b1}};
        end else begin
            out_d = CNT_W'(sum_s - dec_s);
        end
    end

    // State registers with synchronous flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q <= '0;
            out_q <= '0;
        end else if (flush_i) begin
            rdy_q <= '0;
            out_q <= '0;
        end else begin
            rdy_q <= rdy_d;
            out_q <= out_d;
        end
    end

    assign rdy_cnt_o = rdy_q;
    assign out_cnt_o = out_q;

endmodule

// File: rtl/result_scoreboard.sv
// Tracks in-flight destination tags from the four result lanes and stalls
// decode on load-use / multiplier hazards or writer-count saturation.
module result_scoreboard
    import cpu_pkg::*;
#(
    parameter int LAT_ALU = DEF_LAT_ALU,
    parameter int LAT_MUL = DEF_LAT_MUL,
    parameter int LAT_LS  = DEF_LAT_LS,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         iss_valid,
    input  logic [NUM_LANES-1:0]         iss_dvld,
    input  logic [NUM_LANES*REG_W-1:0]   iss_dtag,
    input  logic [NUM_SRC-1:0]           iss_svld,
    input  logic [NUM_SRC*REG_W-1:0]     iss_stag,
    input  logic [NUM_LANES-1:0]         ret_vld,
    input  logic [NUM_LANES*REG_W-1:0]   ret_tag,
    input  logic                         flush,
    output logic                         stall,
    output logic [NUM_REGS-1:0]          busy,
    output logic                         err_dup
);

    logic [RDY_W-1:0]      rdy_cnt_s  [NUM_REGS];
    logic [CNT_W-1:0]      out_cnt_s  [NUM_REGS];
    logic                  load_s     [NUM_REGS];
    logic [RDY_W-1:0]      load_val_s [NUM_REGS];
    logic [LANE_CNT_W-1:0] inc_s      [NUM_REGS];
    logic [LANE_CNT_W-1:0] dec_s      [NUM_REGS];
    logic                  stall_s;
    logic                  fire_s;
    logic                  dup_s;
    logic                  err_dup_q, err_dup_d;

    function automatic logic [RDY_W-1:0] lane_rdy(input int lane);
        case (lane)
            LANE_M:  return rdy_load(LAT_MUL);
            LANE_LS: return rdy_load(LAT_LS);
            default: return rdy_load(LAT_ALU);
        endcase
    endfunction

    // Hazard detection always reads pre-bundle state, so intra-bundle RAW never stalls.
    always_comb begin
        stall_s = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            stall_s = stall_s | (iss_valid & iss_svld[s]
                      & (iss_stag[s*REG_W +: REG_W] != '0)
                      & (rdy_cnt_s[iss_stag[s*REG_W +: REG_W]] != '0));
        end
        for (int l = 0; l < NUM_LANES; l++) begin
            stall_s = stall_s | (iss_valid & iss_dvld[l]
                      & (iss_dtag[l*REG_W +: REG_W] != '0)
                      & (out_cnt_s[iss_dtag[l*REG_W +: REG_W]] == {CNT_W{1'b1}}));
        end
    end

    assign fire_s = iss_valid & ~stall_s;
    assign stall  = stall_s;

    // Per-register issue/retire decode; two lanes to one reg load the longer latency.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            load_s[r]     = 1'b0;
            load_val_s[r] = '0;
            inc_s[r]      = '0;
            dec_s[r]      = '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                logic hit_v;
                logic ret_v;
                hit_v = fire_s & iss_dvld[l] & (r != 0)
                        & (iss_dtag[l*REG_W +: REG_W] == REG_W'(r));
                ret_v = ret_vld[l] & (r != 0)
                        & (ret_tag[l*REG_W +: REG_W] == REG_W'(r));
                load_s[r]     = load_s[r] | hit_v;
                load_val_s[r] = (hit_v && (lane_rdy(l) > load_val_s[r])) ? lane_rdy(l) : load_val_s[r];
                inc_s[r]      = inc_s[r] + LANE_CNT_W'(hit_v);
                dec_s[r]      = dec_s[r] + LANE_CNT_W'(ret_v);
            end
        end
    end

    genvar gr;
    generate
        for (gr = 0; gr < NUM_REGS; gr++) begin : g_entry
            if (gr == 0) begin : g_r0
                assign rdy_cnt_s[gr] = '0;
                assign out_cnt_s[gr] = '0;
            end else begin : g_rn
                sb_entry #(.CNT_W(CNT_W)) u_entry (
                    .clk        (clk),
                    .rst        (rst),
                    .flush_i    (flush),
                    .load_i     (load_s[gr]),
                    .load_val_i (load_val_s[gr]),
                    .inc_n_i    (inc_s[gr]),
                    .dec_m_i    (dec_s[gr]),
                    .rdy_cnt_o  (rdy_cnt_s[gr]),
                    .out_cnt_o  (out_cnt_s[gr])
                );
            end
        end
    endgenerate

    // Busy view and duplicate-destination detection.
    always_comb begin
        busy  = '0;
        dup_s = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy[r] = (out_cnt_s[r] != '0);
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int j = i + 1; j < NUM_LANES; j++) begin
                dup_s = dup_s | (iss_dvld[i] & iss_dvld[j]
                        & (iss_dtag[i*REG_W +: REG_W] != '0)
                        & (iss_dtag[i*REG_W +: REG_W] == iss_dtag[j*REG_W +: REG_W]));
            end
        end
        err_dup_d = err_dup_q | (fire_s & dup_s);
    end

    // Sticky duplicate-issue flag, cleared only by reset or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_dup_q <= 1'b0;
        end else if (flush) begin
            err_dup_q <= 1'b0;
        end else begin
            err_dup_q <= err_dup_d;
        end
    end

    assign err_dup = err_dup_q;

endmodule

// File: tb/tb_result_scoreboard.sv
// Table-driven bench for result_scoreboard: stall checked before each edge,
// expected busy/err_dup queued and compared after the edge.
module tb_result_scoreboard;

    typedef struct {
        logic        vld;
        logic [3:0]  dv;
        logic [19:0] dt;
        logic [8:0]  sv;
        logic [44:0] st;
        logic [3:0]  rv;
        logic [19:0] rt;
        logic        fl;
        logic        es;
        logic [31:0] eb;
        logic        ee;
    } vec_t;

    typedef struct {
        logic [31:0] busy;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        iss_valid;
    logic [3:0]  iss_dvld;
    logic [19:0] iss_dtag;
    logic [8:0]  iss_svld;
    logic [44:0] iss_stag;
    logic [3:0]  ret_vld;
    logic [19:0] ret_tag;
    logic        flush;
    logic        stall;
    logic [31:0] busy;
    logic        err_dup;

    int checks;
    int failures;
    vec_t tbl[$];
    exp_t exp_q[$];

    result_scoreboard dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_dvld  (iss_dvld),
        .iss_dtag  (iss_dtag),
        .iss_svld  (iss_svld),
        .iss_stag  (iss_stag),
        .ret_vld   (ret_vld),
        .ret_tag   (ret_tag),
        .flush     (flush),
        .stall     (stall),
        .busy      (busy),
        .err_dup   (err_dup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] lt(input int l, input int t);
        logic [19:0] v;
        v = 20'd0;
        v[l*5 +: 5] = 5'(t);
        return v;
    endfunction

    function automatic logic [44:0] sl(input int s, input int t);
        logic [44:0] v;
        v = 45'd0;
        v[s*5 +: 5] = 5'(t);
        return v;
    endfunction

    function automatic logic [31:0] b(input int r);
        return 32'd1 << r;
    endfunction

    function automatic vec_t mk(input logic vld, input logic [3:0] dv, input logic [19:0] dt,
                                input logic [8:0] sv, input logic [44:0] st,
                                input logic [3:0] rv, input logic [19:0] rt, input logic fl,
                                input logic es, input logic [31:0] eb, input logic ee);
        vec_t v;
        v.vld = vld; v.dv = dv; v.dt = dt; v.sv = sv; v.st = st;
        v.rv = rv; v.rt = rt; v.fl = fl; v.es = es; v.eb = eb; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        exp_t e;
        @(negedge clk);
        iss_valid = v.vld; iss_dvld = v.dv; iss_dtag = v.dt;
        iss_svld  = v.sv;  iss_stag = v.st;
        ret_vld   = v.rv;  ret_tag  = v.rt; flush = v.fl;
        #1;
        chk({name, "_stall"}, {31'd0, stall}, {31'd0, v.es});
        e.busy = v.eb;
        e.err  = v.ee;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({name, "_busy"}, busy, e.busy);
        chk({name, "_err"}, {31'd0, err_dup}, {31'd0, e.err});
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; iss_valid = 1'b0; iss_dvld = 4'd0; iss_dtag = 20'd0;
        iss_svld = 9'd0; iss_stag = 45'd0; ret_vld = 4'd0; ret_tag = 20'd0; flush = 1'b0;

        // load-use
        tbl.push_back(mk(1'b1, 4'b1000, lt(3,7), 9'd0, 45'd0, 4'd0, 20'd0, 1'b0, 1'b0, b(7), 1'b0));
        tbl.push_back(mk(1'b1, 4'd0, 20'd0, 9'd1, sl(0,7), 4'd0, 20'd0, 1'b0, 1'b1, b(7), 1'b0));
        tbl.push_back(mk(1'b1, 4'd0, 20'd0, 9'd1, sl(0,7), 4'd0, 20'd0, 1'b0, 1'b0, b(7), 1'b0));
        tbl.push_back(mk(1'b0, 4'd0, 20'd0, 9'd0, 45'd0, 4'b1000, lt(3,7), 1'b0, 1'b0, 32'd0, 1'b0));
        // multiplier, then ALU back-to-back, then intra-bundle RAW
        tbl.push_back(mk(1'b1, 4'b0100, lt(2,12), 9'd0, 45'd0, 4'd0, 20'd0, 1'b0, 1'b0, b(12), 1'b0));
        tbl.push_back(mk(1'b1, 4'd0, 20'd0, 9'b000010000, sl(4,12), 4'd0, 20'd0, 1'b0, 1'b1, b(12), 1'b0));
        tbl.push_back(mk(1'b1, 4'd0, 20'd0, 9'b000010000, sl(4,12), 4'd0, 20'd0, 1'b0, 1'b1, b(12), 1'b0));
        tbl.push_back(mk(1'b1, 4'd0, 20'd0, 9'b000010000, sl(4,12), 4'd0, 20'd0, 1'b0, 1'b0, b(12), 1'b0));
        tbl.push_back(mk(1'b1, 4'b0001, lt(0,3), 9'd0, 45'd0, 4'd0, 20'd0, 1'b0, 1'b0, b(12)|b(3), 1'b0));
        tbl.push_back(mk(1'b1, 4'd0, 20'd0, 9'b000000100, sl(2,3), 4'd0, 20'd0, 1'b0, 1'b0, b(12)|b(3), 1'b0));
        tbl.push_back(mk(1'b1, 4'b0100, lt(2,13), 9'b001000000, sl(6,13), 4'b0101, lt(2,12)|lt(0,3),
                         1'b0, 1'b0, b(13), 1'b0));
        tbl.push_back(mk(1'b0, 4'd0, 20'd0, 9'd0, 45'd0, 4'b0100, lt(2,13), 1'b0, 1'b0, 32'd0, 1'b0));
        // WAW with retire overlap
        tbl.push_back(mk(1'b1, 4'b0001, lt(0,9), 9'd0, 45'd0, 4'd0, 20'd0, 1'b0, 1'b0, b(9), 1'b0));
        tbl.push_back(mk(1'b1, 4'b0010, lt(1,9), 9'd0, 45'd0, 4'd0, 20'd0, 1'b0, 1'b0, b(9), 1'b0));
        tbl.push_back(mk(1'b0, 4'd0, 20'd0, 9'd0, 45'd0, 4'b0001, lt(0,9), 1'b0, 1'b0, b(9), 1'b0));
        tbl.push_back(mk(1'b1, 4'b1000, lt(3,9), 9'd0, 45'd0, 4'b0010, lt(1,9), 1'b0, 1'b0, b(9), 1'b0));
        tbl.push_back(mk(1'b1, 4'd0, 20'd0, 9'd1, sl(0,9), 4'd0, 20'd0, 1'b0, 1'b1, b(9), 1'b0));
        tbl.push_back(mk(1'b0, 4'd0, 20'd0, 9'd0, 45'd0, 4'b1000, lt(3,9), 1'b0, 1'b0, 32'd0, 1'b0));
        // r0 and duplicate destinations
        tbl.push_back(mk(1'b1, 4'b0001, 20'd0, 9'd1, 45'd0, 4'd0, 20'd0, 1'b0, 1'b0, 32'd0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0011, 20'd0, 9'd0, 45'd0, 4'd0, 20'd0, 1'b0, 1'b0, 32'd0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0011, lt(0,4)|lt(1,4), 9'd0, 45'd0, 4'd0, 20'd0, 1'b0, 1'b0, b(4), 1'b1));
        tbl.push_back(mk(1'b0, 4'd0, 20'd0, 9'd0, 45'd0, 4'd0, 20'd0, 1'b0, 1'b0, b(4), 1'b1));
        tbl.push_back(mk(1'b0, 4'd0, 20'd0, 9'd0, 45'd0, 4'b0001, lt(0,4), 1'b0, 1'b0, b(4), 1'b1));
        tbl.push_back(mk(1'b1, 4'b0001, lt(0,6), 9'd0, 45'd0, 4'd0, 20'd0, 1'b1, 1'b0, 32'd0, 1'b0));
        // retire on an idle reg must not underflow
        tbl.push_back(mk(1'b0, 4'd0, 20'd0, 9'd0, 45'd0, 4'b0001, lt(0,5), 1'b0, 1'b0, 32'd0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0001, lt(0,5), 9'd0, 45'd0, 4'd0, 20'd0, 1'b0, 1'b0, b(5), 1'b0));
        tbl.push_back(mk(1'b0, 4'd0, 20'd0, 9'd0, 45'd0, 4'b0001, lt(0,5), 1'b0, 1'b0, 32'd0, 1'b0));
        // no stall without iss_valid, then flush
        tbl.push_back(mk(1'b1, 4'b1000, lt(3,8), 9'd0, 45'd0, 4'd0, 20'd0, 1'b0, 1'b0, b(8), 1'b0));
        tbl.push_back(mk(1'b0, 4'd0, 20'd0, 9'd1, sl(0,8), 4'd0, 20'd0, 1'b0, 1'b0, b(8), 1'b0));
        tbl.push_back(mk(1'b0, 4'd0, 20'd0, 9'd0, 45'd0, 4'd0, 20'd0, 1'b1, 1'b0, 32'd0, 1'b0));

        // reset state
        @(negedge clk);
        #1;
        chk("reset_busy", busy, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_err", {31'd0, err_dup}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec($sformatf("v%0d", i), tbl[i]);
        end

        // saturation: seven writers fill r2, the eighth waits for a retire
        for (int k = 0; k < 7; k++) begin
            run_vec($sformatf("sat_fill%0d", k),
                    mk(1'b1, 4'b0001, lt(0,2), 9'd0, 45'd0, 4'd0, 20'd0, 1'b0, 1'b0, b(2), 1'b0));
        end
        run_vec("sat_full", mk(1'b1, 4'b0001, lt(0,2), 9'd0, 45'd0, 4'd0, 20'd0, 1'b0, 1'b1, b(2), 1'b0));
        run_vec("sat_ret", mk(1'b1, 4'b0001, lt(0,2), 9'd0, 45'd0, 4'b0001, lt(0,2), 1'b0, 1'b1, b(2), 1'b0));
        run_vec("sat_fire", mk(1'b1, 4'b0001, lt(0,2), 9'd0, 45'd0, 4'd0, 20'd0, 1'b0, 1'b0, b(2), 1'b0));
        run_vec("sat_full2", mk(1'b1, 4'b0001, lt(0,2), 9'd0, 45'd0, 4'd0, 20'd0, 1'b0, 1'b1, b(2), 1'b0));
        run_vec("sat_flush", mk(1'b0, 4'd0, 20'd0, 9'd0, 45'd0, 4'd0, 20'd0, 1'b1, 1'b0, 32'd0, 1'b0));

        // reset mid-operation
        run_vec("rst_issue", mk(1'b1, 4'b1000, lt(3,5), 9'd0, 45'd0, 4'd0, 20'd0, 1'b0, 1'b0, b(5), 1'b0));
        @(negedge clk);
        iss_valid = 1'b1; iss_dvld = 4'd0; iss_dtag = 20'd0; iss_svld = 9'd1; iss_stag = sl(0,5);
        ret_vld = 4'd0; ret_tag = 20'd0; flush = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 32'd0);
        chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec("rst_src", mk(1'b1, 4'd0, 20'd0, 9'd1, sl(0,5), 4'd0, 20'd0, 1'b0, 1'b0, 32'd0, 1'b0));

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_scoreboard.md
Name: result_scoreboard

Overview:
- Producer-side companion to the ID-stage forwarding network. Tracks every in-flight destination tag issued by the four result lanes (A0, A1, M, LS) from issue until writeback retire.
- Raises a decode stall when a source operand's producer has not yet reached a forwardable stage: load-use and multiplier latency.
- Exposes a per-register busy vector for debug and for the branch unit.

Parameters:
- LAT_ALU, 1, cycles from issue until A0/A1 result is forwardable (from EX)
- LAT_MUL, 3, cycles from issue until M result is forwardable
- LAT_LS, 2, cycles from issue until LS result is forwardable (from MEM)
- CNT_W, 3, width of per-register outstanding-writer counter

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- iss_valid  in  1  ID bundle present
- iss_dvld  in  4  dest valid per lane {LS,M,A1,A0}
- iss_dtag  in  20  dest tags, 5b per lane, A0 in [4:0]
- iss_svld  in  9  source valid {LS_R2,LS_R1,LS_R0,M_R1,M_R0,A1_R1,A1_R0,A0_R1,A0_R0}
- iss_stag  in  45  source tags, 5b each, same order
- ret_vld  in  4  WB retire valid per lane
- ret_tag  in  20  WB retire tags per lane
- flush  in  1  pipeline flush; clears all tracking state
- stall  out  1  hold ID bundle this cycle
- busy  out  32  bit r set when reg r has ≥1 outstanding writer
- err_dup  out  1  sticky: bundle issued with duplicate dest tags

Behaviour:
- State per reg r (1..31): rdy_cnt[r] (2b), out_cnt[r] (CNT_W). r0 is never tracked; tag 0 is ignored everywhere.
- Reset / flush: all rdy_cnt, out_cnt and err_dup = 0. Outputs therefore reset to stall=0, busy=0, err_dup=0. Flush is synchronous and has priority over same-cycle issue and retire.
- stall is combinational. It is 1 when iss_valid and any of the following holds:
  - any valid nonzero source tag t has rdy_cnt[t]≠0;
  - any valid nonzero dest tag d has out_cnt[d] at max (2^CNT_W−1).
- Sources always see pre-bundle state (intra-bundle RAW is not a hazard; lanes read the old value).
- fire = iss_valid & ~stall.
- On fire, for each valid lane with dest d≠0:
  - out_cnt[d] += 1;
  - rdy_cnt[d] = lane latency − 1 (ALU→0, LS→1, MUL→2). The new value overrides the decrement this cycle.
- Every cycle, each rdy_cnt not being loaded that is nonzero decrements by 1.
- On each ret_vld lane with tag≠0, out_cnt[tag] −= 1.
- Simultaneous issue and retire on the same reg: out_cnt changes by the net count (+issues −retires), computed in one cycle.
- Retire with out_cnt=0 is ignored (no underflow).
- WAW: a new issue to a busy reg reloads rdy_cnt; out_cnt keeps counting, so an older retire does not clear busy.
- Duplicate nonzero dest tags in a fired bundle set err_dup (sticky until reset/flush). Both lanes count; out_cnt takes +2.
- busy[r] = (out_cnt[r]≠0); busy[0] = 0. busy is registered state, so it updates the cycle after fire or retire.
- Latency: a dependent source is stall-free on cycle fire+LAT for LS/MUL, and immediately for ALU.

Decomposition:
- Shared package (cpu_pkg): lane index constants (LANE_A0=0, LANE_A1=1, LANE_M=2, LANE_LS=3); source slot indices 0..8; REG_W=5; NUM_REGS=32; default latency constants.
- One natural sub-module: sb_entry — a single register's rdy_cnt and out_cnt with load, decrement, increment-by-n and decrement-by-m inputs. Instantiate 31 times via generate.

Test Plan:
- Reset mid-operation: issue LS dest r5, assert rst the next cycle → busy=0, stall=0. Re-issue A0 src r5 → fires immediately.
- Load-use: fire LS dest r7. Next cycle issue A0 src r7 → stall=1 for exactly 1 cycle, fires on the 2nd cycle. Retire LS r7 → busy[7]=0 the following cycle.
- Multiplier: fire M dest r12, then M src r12 → stall=1 for 2 cycles, then fire. ALU dest r3 followed by ALU src r3 → no stall.
- WAW plus retire overlap: fire A0 r9, then A1 r9 → out_cnt=2. Retire one → busy[9] stays 1. Retire the second and issue LS r9 in the same cycle → busy[9]=1, out_cnt=1.
- r0 and duplicates: bundle with A0 dest r0 and src r0 → no tracking, no stall. Bundle with A0/A1 both dest r4 → err_dup=1 and stays 1; flush → err_dup=0, busy=0.
- Saturation: 7 fires to r2 without retire; 8th issue to r2 → stall=1 until one retire, then fires.
